sad_window_scanner: RTL and testbench
=====================================

Name: sad_window_scanner

Overview:
- Writeback-side stage directly downstream of the SAD2 pipeline register.
- Consumes one SAD value per valid cycle for the current search-window position and tracks the raster-scan position (x, y) over the frame.
- Keeps the running minimum SAD and its coordinates, which drive the min/minX/minY values the writeback path commits to registers.
- Tells the upstream memory/address stage when a row wraps (rowSkip) and when the search is done.

Parameters:
- SAD_W, 32, width of SAD values and of the minimum register
- COORD_W, 8, width of frame/window dimensions and of x/y coordinates
- CNT_W, 16, width of the evaluated-window counter

Ports:
- Clk  input  1  system clock, rising-edge
- Reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse: latch config, clear results, begin scan
- frame_cols  input  COORD_W  frame width in pixels, sampled on start
- frame_rows  input  COORD_W  frame height in pixels, sampled on start
- win_cols  input  COORD_W  window width, sampled on start
- win_rows  input  COORD_W  window height, sampled on start
- sad_valid  input  1  sad_in holds the SAD of window (cur_x, cur_y)
- sad_in  input  SAD_W  SAD value from the SAD2 stage
- cur_x  output  COORD_W  column of the window the next sad_valid refers to
- cur_y  output  COORD_W  row of the window the next sad_valid refers to
- row_skip  output  1  one-cycle pulse when x wraps to 0 and y increments
- min_sad  output  SAD_W  running minimum SAD
- min_x  output  COORD_W  x of min_sad
- min_y  output  COORD_W  y of min_sad
- win_count  output  CNT_W  number of SADs accepted since start
- busy  output  1  high in SCAN
- done  output  1  level, high in DONE
- cfg_err  output  1  last start carried an illegal config

Behaviour:
- Reset (asynchronous, active-high) applies these values:
  - state = IDLE.
  - cur_x, cur_y, min_x, min_y, win_count = 0.
  - min_sad = all ones.
  - row_skip, busy, done, cfg_err = 0.
- States are IDLE, SCAN and DONE. Encoding constants live in the package.
- x_last = frame_cols - win_cols; y_last = frame_rows - win_rows. Both are computed once on start and held in registers.
- start is honoured in any state, and start mid-SCAN aborts and restarts. On the start edge:
  - min_sad = all ones.
  - cur_x, cur_y, min_x, min_y, win_count = 0.
  - done = 0.
  - Illegal config (any dimension 0, win_cols > frame_cols, or win_rows > frame_rows): cfg_err = 1, go to DONE.
  - Otherwise: cfg_err = 0, go to SCAN.
- If start and sad_valid are high in the same cycle, start wins and the SAD is dropped.
- sad_valid is ignored in IDLE and DONE, with no state or counter change.
- In SCAN, on each sad_valid:
  - If sad_in < min_sad (unsigned, strict), then min_sad = sad_in, min_x = cur_x, min_y = cur_y. Ties keep the earlier raster position.
  - win_count increments. It saturates at all ones.
  - If cur_x != x_last, then cur_x++.
  - Else if cur_y != y_last, then cur_x = 0, cur_y++, and row_skip pulses for the following cycle.
  - Else (last window): go to DONE, and cur_x/cur_y hold at x_last/y_last.
- Latency: min_sad, min_x, min_y, win_count, cur_x and cur_y reflect a sad_valid on the next rising edge.
- done rises on the same edge that registers the final comparison, so the min outputs are final whenever done = 1.
- A single-window frame (x_last = y_last = 0) reaches DONE after one sad_valid, with win_count = 1.
- DONE holds all results until the next start or Reset.
- busy = (state == SCAN); done = (state == DONE).
- Back-to-back sad_valid on consecutive cycles is legal. There is no backpressure, so the block is always ready.

Decomposition:
- Shared package sad_pkg holds:
  - state encodings IDLE/SCAN/DONE;
  - SAD_MAX (all ones of SAD_W), used as the minimum's reset and clear value;
  - default SAD_W and COORD_W, shared with SAD1_sub_mod, SAD2_sub_mod and Writeback_sub_mod.
- One sub-module is natural: sad_min_tracker, the compare-and-update register for min_sad/min_x/min_y, with clear and valid inputs.
- The FSM and the x/y counters stay in the top of the block.

Test Plan:
- Reset mid-SCAN after 3 SADs -> all outputs return to reset values immediately (asynchronously), state IDLE, min_sad = 0xFFFFFFFF.
- frame 4x4, window 2x2, SADs 9,7,8,5,6,5,4,9,9 (9 windows) -> row_skip pulses after the 3rd and 6th SAD; done after the 9th; min_sad = 4 at (0,2); win_count = 9.
- Tie: frame 3x2, window 2x2, SADs 5,5 -> min_sad = 5 at (0,0); done; win_count = 2.
- start with win_cols = 5, frame_cols = 4 -> cfg_err = 1, done = 1 on the next edge; sad_valid pulses leave win_count = 0 and min_sad = 0xFFFFFFFF.
- start reasserted after 2 of 9 SADs, together with sad_valid = 1, sad_in = 0 -> SAD dropped; counters cleared; busy stays 1; the following full 9-SAD run gives correct results.
- frame = window = 8x8, one sad_valid with sad_in = 0x1234 -> done next edge; min_sad = 0x1234 at (0,0); row_skip never pulses.

Source files
------------

// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared widths, scanner state encoding and SAD clear value
package sad_pkg;

    localparam int SAD_W_DEF   = 32;
    localparam int COORD_W_DEF = 8;

    localparam logic [SAD_W_DEF-1:0] SAD_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scanState_t;

endpackage

// File: rtl/sad_min_tracker.sv
// rtl/sad_min_tracker.sv - running minimum SAD with the raster position where it occurred
module sad_min_tracker
    import sad_pkg::*;
#(
    parameter int SAD_W   = SAD_W_DEF,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               clear,
    input  logic               valid,
    input  logic [SAD_W-1:0]   sadIn,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [SAD_W-1:0]   minSad,
    output logic [COORD_W-1:0] minX,
    output logic [COORD_W-1:0] minY
);

    localparam logic [SAD_W-1:0] MIN_INIT = SAD_W'(SAD_MAX);

    // Strict compare: on a tie the earlier raster position is kept.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            minSad <= MIN_INIT;
            minX   <= '0;
            minY   <= '0;
        end else if (clear) begin
            minSad <= MIN_INIT;
            minX   <= '0;
            minY   <= '0;
        end else if (valid && (sadIn < minSad)) begin
            minSad <= sadIn;
            minX   <= x;
            minY   <= y;
        end
    end

endmodule

// File: rtl/sad_window_scanner.sv
// rtl/sad_window_scanner.sv - raster scan of search-window positions tracking the minimum SAD
module sad_window_scanner
    import sad_pkg::*;
#(
    parameter int SAD_W   = SAD_W_DEF,
    parameter int COORD_W = COORD_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic [COORD_W-1:0] frame_cols,
    input  logic [COORD_W-1:0] frame_rows,
    input  logic [COORD_W-1:0] win_cols,
    input  logic [COORD_W-1:0] win_rows,
    input  logic               sad_valid,
    input  logic [SAD_W-1:0]   sad_in,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic               row_skip,
    output logic [SAD_W-1:0]   min_sad,
    output logic [COORD_W-1:0] min_x,
    output logic [COORD_W-1:0] min_y,
    output logic [CNT_W-1:0]   win_count,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    scanState_t         state, nextState;
    logic [COORD_W-1:0] xLast, yLast;
    logic               cfgBad, accept, atRowEnd, atLastRow;

    assign cfgBad = (frame_cols == '0) || (frame_rows == '0) ||
                    (win_cols == '0) || (win_rows == '0) ||
                    (win_cols > frame_cols) || (win_rows > frame_rows);

    // start takes priority, so a SAD arriving with it is dropped.
    assign accept    = (state == SCAN) && sad_valid && !start;
    assign atRowEnd  = (cur_x == xLast);
    assign atLastRow = (cur_y == yLast);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (start) begin
            nextState = cfgBad ? DONE : SCAN;
        end else if (accept && atRowEnd && atLastRow) begin
            nextState = DONE;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            xLast     <= '0;
            yLast     <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            win_count <= '0;
            row_skip  <= 1'b0;
            cfg_err   <= 1'b0;
        end else if (start) begin
            xLast     <= frame_cols - win_cols;
            yLast     <= frame_rows - win_rows;
            cur_x     <= '0;
            cur_y     <= '0;
            win_count <= '0;
            row_skip  <= 1'b0;
            cfg_err   <= cfgBad;
        end else begin
            row_skip <= 1'b0;
            if (accept) begin
                if (win_count != '1) begin
                    win_count <= win_count + 1'b1;
                end
                // On the last window x/y hold so they still name it in DONE.
                if (!atRowEnd) begin
                    cur_x <= cur_x + 1'b1;
                end else if (!atLastRow) begin
                    cur_x    <= '0;
                    cur_y    <= cur_y + 1'b1;
                    row_skip <= 1'b1;
                end
            end
        end
    end

    sad_min_tracker #(
        .SAD_W   (SAD_W),
        .COORD_W (COORD_W)
    ) u_min_tracker (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  (start),
        .valid  (accept),
        .sadIn  (sad_in),
        .x      (cur_x),
        .y      (cur_y),
        .minSad (min_sad),
        .minX   (min_x),
        .minY   (min_y)
    );

    assign busy = (state == SCAN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sad_window_scanner.sv
// tb/tb_sad_window_scanner.sv - randomized and directed checks of the window scanner against a raster model
module tb_sad_window_scanner;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [7:0]  frame_cols, frame_rows, win_cols, win_rows;
    logic        sad_valid;
    logic [31:0] sad_in;
    logic [7:0]  cur_x, cur_y, min_x, min_y;
    logic        row_skip, busy, done, cfg_err;
    logic [31:0] min_sad;
    logic [15:0] win_count;

    int nTests = 0;
    int nFail  = 0;

    // Reference: windows are numbered in raster order, index i sits at (i % nx, i / nx).
    bit          mLegal;
    int          mXl, mYl, mNx, mTotal, mK;
    logic [31:0] mMin;
    int          mMinX, mMinY;

    sad_window_scanner dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .frame_cols (frame_cols),
        .frame_rows (frame_rows),
        .win_cols   (win_cols),
        .win_rows   (win_rows),
        .sad_valid  (sad_valid),
        .sad_in     (sad_in),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .row_skip   (row_skip),
        .min_sad    (min_sad),
        .min_x      (min_x),
        .min_y      (min_y),
        .win_count  (win_count),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        check({tag, " cur_x"}, 32'(cur_x), 32'd0);
        check({tag, " cur_y"}, 32'(cur_y), 32'd0);
        check({tag, " min_sad"}, min_sad, 32'hFFFF_FFFF);
        check({tag, " min_x"}, 32'(min_x), 32'd0);
        check({tag, " min_y"}, 32'(min_y), 32'd0);
        check({tag, " win_count"}, 32'(win_count), 32'd0);
        check({tag, " row_skip"}, 32'(row_skip), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " cfg_err"}, 32'(cfg_err), 32'd0);
    endtask

    task automatic doStart(input int fc, input int fr, input int wc, input int wr,
                           input bit withSad, input logic [31:0] s);
        @(negedge Clk);
        frame_cols = 8'(fc);
        frame_rows = 8'(fr);
        win_cols   = 8'(wc);
        win_rows   = 8'(wr);
        start      = 1'b1;
        sad_valid  = withSad;
        sad_in     = s;
        @(posedge Clk);
        #1;
        start     = 1'b0;
        sad_valid = 1'b0;
        mLegal = (fc != 0) && (fr != 0) && (wc != 0) && (wr != 0) && (wc <= fc) && (wr <= fr);
        mXl    = mLegal ? fc - wc : 0;
        mYl    = mLegal ? fr - wr : 0;
        mNx    = mXl + 1;
        mTotal = mNx * (mYl + 1);
        mK     = 0;
        mMin   = 32'hFFFF_FFFF;
        mMinX  = 0;
        mMinY  = 0;
        check("start busy", 32'(busy), 32'(mLegal));
        check("start done", 32'(done), 32'(!mLegal));
        check("start cfg_err", 32'(cfg_err), 32'(!mLegal));
        check("start win_count", 32'(win_count), 32'd0);
        check("start cur_x", 32'(cur_x), 32'd0);
        check("start cur_y", 32'(cur_y), 32'd0);
        check("start min_sad", min_sad, 32'hFFFF_FFFF);
        check("start row_skip", 32'(row_skip), 32'd0);
    endtask

    task automatic sendSad(input logic [31:0] s);
        bit taken;
        int ex, ey;
        @(negedge Clk);
        sad_valid = 1'b1;
        sad_in    = s;
        @(posedge Clk);
        #1;
        sad_valid = 1'b0;
        taken = mLegal && (mK < mTotal);
        if (taken) begin
            if (s < mMin) begin
                mMin  = s;
                mMinX = mK % mNx;
                mMinY = mK / mNx;
            end
            mK++;
        end
        if (!mLegal) begin
            ex = 0;
            ey = 0;
        end else if (mK < mTotal) begin
            ex = mK % mNx;
            ey = mK / mNx;
        end else begin
            ex = mXl;
            ey = mYl;
        end
        check("sad min_sad", min_sad, mMin);
        check("sad min_x", 32'(min_x), 32'(mMinX));
        check("sad min_y", 32'(min_y), 32'(mMinY));
        check("sad win_count", 32'(win_count), 32'(mK));
        check("sad cur_x", 32'(cur_x), 32'(ex));
        check("sad cur_y", 32'(cur_y), 32'(ey));
        check("sad row_skip", 32'(row_skip), 32'(taken && (mK < mTotal) && (mK % mNx == 0)));
        check("sad busy", 32'(busy), 32'(mLegal && (mK < mTotal)));
        check("sad done", 32'(done), 32'(!mLegal || (mK >= mTotal)));
    endtask

    logic [31:0] seq4x4 [9] = '{32'd9, 32'd7, 32'd8, 32'd5, 32'd6, 32'd5, 32'd4, 32'd9, 32'd9};

    initial begin
        Reset      = 1'b1;
        start      = 1'b0;
        frame_cols = '0;
        frame_rows = '0;
        win_cols   = '0;
        win_rows   = '0;
        sad_valid  = 1'b0;
        sad_in     = '0;
        repeat (2) @(posedge Clk);
        #1;
        checkIdle("reset");
        @(negedge Clk);
        Reset = 1'b0;

        // sad_valid in IDLE is ignored
        @(negedge Clk);
        sad_valid = 1'b1;
        sad_in    = 32'd3;
        @(posedge Clk);
        #1;
        sad_valid = 1'b0;
        checkIdle("idle sad");

        // asynchronous reset mid-scan, right after a row wrap
        doStart(4, 4, 2, 2, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) sendSad(seq4x4[i]);
        #2;
        Reset = 1'b1;
        #1;
        checkIdle("async reset");
        @(negedge Clk);
        Reset = 1'b0;

        // 4x4 frame, 2x2 window
        doStart(4, 4, 2, 2, 1'b0, 32'd0);
        for (int i = 0; i < 9; i++) sendSad(seq4x4[i]);
        check("4x4 min_sad", min_sad, 32'd4);
        check("4x4 min_x", 32'(min_x), 32'd0);
        check("4x4 min_y", 32'(min_y), 32'd2);
        check("4x4 win_count", 32'(win_count), 32'd9);
        check("4x4 done", 32'(done), 32'd1);
        sendSad(32'd0);

        // tie keeps the first position
        doStart(3, 2, 2, 2, 1'b0, 32'd0);
        sendSad(32'd5);
        sendSad(32'd5);
        check("tie min_sad", min_sad, 32'd5);
        check("tie min_x", 32'(min_x), 32'd0);
        check("tie done", 32'(done), 32'd1);

        // illegal config
        doStart(4, 4, 5, 2, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) sendSad(32'd1);
        check("cfg win_count", 32'(win_count), 32'd0);
        check("cfg min_sad", min_sad, 32'hFFFF_FFFF);
        doStart(0, 4, 0, 2, 1'b0, 32'd0);

        // restart mid-scan with a colliding SAD of 0
        doStart(4, 4, 2, 2, 1'b0, 32'd0);
        sendSad(32'd50);
        sendSad(32'd60);
        doStart(4, 4, 2, 2, 1'b1, 32'd0);
        for (int i = 0; i < 9; i++) sendSad(32'd20 + 32'($urandom_range(0, 9)));

        // single-window frame
        doStart(8, 8, 8, 8, 1'b0, 32'd0);
        sendSad(32'h1234);
        check("1win min_sad", min_sad, 32'h1234);
        check("1win win_count", 32'(win_count), 32'd1);
        check("1win done", 32'(done), 32'd1);

        // random configurations, small SAD range to provoke ties
        for (int r = 0; r < 8; r++) begin
            int fc, fr, wc, wr;
            fc = $urandom_range(1, 8);
            fr = $urandom_range(1, 8);
            wc = $urandom_range(1, fc);
            wr = $urandom_range(1, fr);
            doStart(fc, fr, wc, wr, 1'b0, 32'd0);
            for (int i = 0; i < mTotal + 2; i++) sendSad(32'($urandom_range(0, 20)));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
